// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side handshake bundle for mem_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding caches and memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 128
);
    logic              ic_req_valid_i;
    logic [ADDR_W-1:0] ic_req_addr_i;
    logic              ic_req_ready_o;
    logic              ic_resp_valid_o;
    logic [DATA_W-1:0] ic_resp_data_o;

    logic              dc_req_valid_i;
    logic [ADDR_W-1:0] dc_req_addr_i;
    logic              dc_req_we_i;
    logic [DATA_W-1:0] dc_req_wdata_i;
    logic              dc_req_ready_o;
    logic              dc_resp_valid_o;
    logic [DATA_W-1:0] dc_resp_data_o;

    logic              mem_req_valid_o;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic              mem_req_we_o;
    logic [DATA_W-1:0] mem_req_wdata_o;
    logic              mem_req_ready_i;
    logic              mem_resp_valid_i;
    logic [DATA_W-1:0] mem_resp_data_i;

    modport slave (
        input  ic_req_valid_i, ic_req_addr_i,
        output ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
        input  dc_req_valid_i, dc_req_addr_i, dc_req_we_i, dc_req_wdata_i,
        output dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
        output mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o,
        input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i
    );

    modport master (
        output ic_req_valid_i, ic_req_addr_i,
        input  ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
        output dc_req_valid_i, dc_req_addr_i, dc_req_we_i, dc_req_wdata_i,
        input  dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
        input  mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o,
        output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory port between the icache and dcache miss paths.
// It keeps one transaction in flight at a time and returns each response to the requester that issued it.
module mem_port_arbiter #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_port_arbiter_if.slave bus,
    output logic             busy_o,
    output logic [CNT_W-1:0] ic_grant_cnt_o,
    output logic [CNT_W-1:0] dc_grant_cnt_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  ic_cnt_q, ic_cnt_d;
    logic [CNT_W-1:0]  dc_cnt_q, dc_cnt_d;

    logic idle;
    logic grant_ic;
    logic grant_dc;

    // On a tie, the requester that did not win last time gets the grant.
    always_comb begin
        idle     = (state_q == ST_IDLE);
        grant_ic = bus.ic_req_valid_i && (!bus.dc_req_valid_i || (last_grant_q == OWN_DC));
        grant_dc = bus.dc_req_valid_i && (!bus.ic_req_valid_i || (last_grant_q == OWN_IC));
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block leaves a signal unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ic_cnt_d     = ic_cnt_q;
        dc_cnt_d     = dc_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_dc) begin
                    owner_d      = OWN_DC;
                    addr_d       = bus.dc_req_addr_i;
                    we_d         = bus.dc_req_we_i;
                    wdata_d      = bus.dc_req_wdata_i;
                    last_grant_d = OWN_DC;
                    dc_cnt_d     = dc_cnt_q + CNT_W'(1);
                    state_d      = ST_REQ;
                end else if (grant_ic) begin
                    owner_d      = OWN_IC;
                    addr_d       = bus.ic_req_addr_i;
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    last_grant_d = OWN_IC;
                    ic_cnt_d     = ic_cnt_q + CNT_W'(1);
                    state_d      = ST_REQ;
                end
            end
            ST_REQ:  if (bus.mem_req_ready_i) state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    rdata_d = bus.mem_resp_data_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= OWN_IC;
            owner_q      <= OWN_IC;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ic_cnt_q     <= '0;
            dc_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ic_cnt_q     <= ic_cnt_d;
            dc_cnt_q     <= dc_cnt_d;
        end
    end

    assign bus.ic_req_ready_o  = idle && grant_ic;
    assign bus.dc_req_ready_o  = idle && grant_dc;

    assign bus.mem_req_valid_o = (state_q == ST_REQ);
    assign bus.mem_req_addr_o  = addr_q;
    assign bus.mem_req_we_o    = we_q;
    assign bus.mem_req_wdata_o = wdata_q;

    assign bus.ic_resp_valid_o = (state_q == ST_RESP) && (owner_q == OWN_IC);
    assign bus.dc_resp_valid_o = (state_q == ST_RESP) && (owner_q == OWN_DC);
    assign bus.ic_resp_data_o  = rdata_q;
    assign bus.dc_resp_data_o  = rdata_q;

    assign busy_o         = !idle;
    assign ic_grant_cnt_o = ic_cnt_q;
    assign dc_grant_cnt_o = dc_cnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It runs a table of directed transactions, hand-written reset and counter-wrap sequences,
// and randomized traffic checked against a grant/counter reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 40;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             busy_o;
    logic [CNT_W-1:0] ic_grant_cnt_o;
    logic [CNT_W-1:0] dc_grant_cnt_o;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .bus            (bus),
        .busy_o         (busy_o),
        .ic_grant_cnt_o (ic_grant_cnt_o),
        .dc_grant_cnt_o (dc_grant_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit                ic_v;
        logic [ADDR_W-1:0] ic_addr;
        bit                dc_v;
        bit                dc_we;
        logic [ADDR_W-1:0] dc_addr;
        logic [DATA_W-1:0] dc_wdata;
        int                ready_delay;
        int                resp_delay;
        logic [DATA_W-1:0] resp_data;
        bit                spur_idle;
        bit                spur_req;
        bit                exp_dc;
    } txn_t;

    int n_tests = 0;
    int n_fail  = 0;
    int both_ready_cnt = 0;

    // Reference model: who won last, and how many grants each side has received.
    bit m_last_dc;
    int m_ic_cnt;
    int m_dc_cnt;

    always @(negedge clk_i) if (bus.ic_req_ready_o && bus.dc_req_ready_o) both_ready_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return {8'($urandom), $urandom};
    endfunction

    function automatic txn_t mk(input bit ic_v, input logic [ADDR_W-1:0] ic_addr, input bit dc_v, input bit dc_we,
                                input logic [ADDR_W-1:0] dc_addr, input logic [DATA_W-1:0] dc_wdata, input int rd,
                                input int rs, input logic [DATA_W-1:0] rdata, input bit si, input bit sr, input bit exp_dc);
        txn_t t;
        t.ic_v = ic_v; t.ic_addr = ic_addr; t.dc_v = dc_v; t.dc_we = dc_we;
        t.dc_addr = dc_addr; t.dc_wdata = dc_wdata; t.ready_delay = rd; t.resp_delay = rs;
        t.resp_data = rdata; t.spur_idle = si; t.spur_req = sr; t.exp_dc = exp_dc;
        return t;
    endfunction

    task automatic clear_inputs();
        bus.ic_req_valid_i   = 1'b0;
        bus.ic_req_addr_i    = '0;
        bus.dc_req_valid_i   = 1'b0;
        bus.dc_req_addr_i    = '0;
        bus.dc_req_we_i      = 1'b0;
        bus.dc_req_wdata_i   = '0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_data_i  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        m_last_dc = 1'b0;
        m_ic_cnt  = 0;
        m_dc_cnt  = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_valid"}, bus.mem_req_valid_o, 0);
        check({tag, "_mem_addr"},  bus.mem_req_addr_o, 0);
        check({tag, "_mem_we"},    bus.mem_req_we_o, 0);
        check({tag, "_mem_wdata"}, bus.mem_req_wdata_o, 0);
        check({tag, "_resp_v"},    {bus.ic_resp_valid_o, bus.dc_resp_valid_o}, 0);
        check({tag, "_resp_d"},    bus.ic_resp_data_o | bus.dc_resp_data_o, 0);
        check({tag, "_busy"},      busy_o, 0);
        check({tag, "_cnts"},      {ic_grant_cnt_o, dc_grant_cnt_o}, 0);
    endtask

    // Runs one complete transaction. When keep is set, both request valids stay asserted afterwards.
    task automatic run_txn(input txn_t t, input bit keep);
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        bit                e_we;
        int                w;
        if (t.spur_idle) begin
            bus.mem_resp_valid_i = 1'b1;
            bus.mem_resp_data_i  = rand128();
            tick();
            bus.mem_resp_valid_i = 1'b0;
            check("idle_spur_busy", busy_o, 0);
            check("idle_spur_resp", {bus.ic_resp_valid_o, bus.dc_resp_valid_o}, 0);
        end
        bus.ic_req_valid_i = t.ic_v;
        bus.ic_req_addr_i  = t.ic_addr;
        bus.dc_req_valid_i = t.dc_v;
        bus.dc_req_addr_i  = t.dc_addr;
        bus.dc_req_we_i    = t.dc_we;
        bus.dc_req_wdata_i = t.dc_wdata;
        #1;
        w = 0;
        while (!(bus.ic_req_ready_o || bus.dc_req_ready_o) && w < 10) begin
            tick();
            w++;
        end
        if (w == 10) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: got no ready, expected one within 10 cycles");
            clear_inputs();
            return;
        end
        check("grant_owner", bus.dc_req_ready_o, t.exp_dc);
        check("ready_onehot", bus.ic_req_ready_o & bus.dc_req_ready_o, 0);

        if (t.exp_dc) begin
            e_addr = t.dc_addr; e_we = t.dc_we; e_wdata = t.dc_wdata; m_dc_cnt++;
        end else begin
            e_addr = t.ic_addr; e_we = 1'b0; e_wdata = '0; m_ic_cnt++;
        end
        m_last_dc = t.exp_dc;

        tick();
        if (!keep) begin
            bus.ic_req_valid_i = 1'b0;
            bus.dc_req_valid_i = 1'b0;
        end
        check("ic_cnt", ic_grant_cnt_o, m_ic_cnt % (1 << CNT_W));
        check("dc_cnt", dc_grant_cnt_o, m_dc_cnt % (1 << CNT_W));

        for (int i = 0; i <= t.ready_delay; i++) begin
            check("req_valid", bus.mem_req_valid_o, 1);
            check("req_addr",  bus.mem_req_addr_o, e_addr);
            check("req_we",    bus.mem_req_we_o, e_we);
            check("req_wdata", bus.mem_req_wdata_o, e_wdata);
            check("req_busy",  busy_o, 1);
            check("req_noresp", {bus.ic_resp_valid_o, bus.dc_resp_valid_o}, 0);
            if (i == t.ready_delay) begin
                bus.mem_req_ready_i = 1'b1;
                if (t.spur_req) begin
                    bus.mem_resp_valid_i = 1'b1;
                    bus.mem_resp_data_i  = ~t.resp_data;
                end
            end
            tick();
            bus.mem_req_ready_i  = 1'b0;
            bus.mem_resp_valid_i = 1'b0;
        end

        for (int j = 0; j <= t.resp_delay; j++) begin
            check("wait_req_low", bus.mem_req_valid_o, 0);
            check("wait_busy",    busy_o, 1);
            check("wait_noresp",  {bus.ic_resp_valid_o, bus.dc_resp_valid_o}, 0);
            if (j == t.resp_delay) begin
                bus.mem_resp_valid_i = 1'b1;
                bus.mem_resp_data_i  = t.resp_data;
            end
            tick();
            bus.mem_resp_valid_i = 1'b0;
            bus.mem_resp_data_i  = rand128();
        end

        check("resp_ic",    bus.ic_resp_valid_o, !t.exp_dc);
        check("resp_dc",    bus.dc_resp_valid_o, t.exp_dc);
        check("resp_busy",  busy_o, 1);
        check("resp_ready", {bus.ic_req_ready_o, bus.dc_req_ready_o}, 0);
        if (!t.exp_dc)
            check("resp_ic_data", bus.ic_resp_data_o, t.resp_data);
        else if (!t.dc_we)
            check("resp_dc_data", bus.dc_resp_data_o, t.resp_data);
        tick();
        check("idle_noresp", {bus.ic_resp_valid_o, bus.dc_resp_valid_o}, 0);
        check("idle_busy",   busy_o, 0);
    endtask

    txn_t vec [6];
    txn_t t;

    initial begin
        vec[0] = mk(1, 40'h200, 0, 0, 40'h0, '0, 0, 0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0, 0);
        vec[1] = mk(0, 40'h0, 1, 1, 40'h1000, 128'hDEADBEEF, 5, 1, 128'h0, 0, 0, 1);
        vec[2] = mk(1, 40'h340, 1, 0, 40'h2200, '0, 1, 2, 128'hCAFE_F00D, 1, 1, 0);
        vec[3] = mk(1, 40'h380, 1, 0, 40'h2240, '0, 0, 1, 128'hABCD_0123_4567, 0, 0, 1);
        vec[4] = mk(0, 40'h0, 1, 0, 40'hFF_FFFF_FFC0, '0, 2, 3, 128'h5A5A, 1, 0, 1);
        vec[5] = mk(1, 40'h3C0, 1, 1, 40'h4000, 128'h77, 0, 0, 128'h9999, 0, 1, 0);

        clear_inputs();
        rst_i = 1'b1;
        tick();
        check_outputs_zero("rst");
        check("rst_ready", {bus.ic_req_ready_o, bus.dc_req_ready_o}, 0);
        rst_i = 1'b0;
        m_last_dc = 1'b0;
        m_ic_cnt  = 0;
        m_dc_cnt  = 0;

        for (int k = 0; k < 6; k++) run_txn(vec[k], 1'b0);

        // Both requesters valid continuously from reset: DC, IC, DC, IC.
        do_reset();
        t = mk(1, 40'h500, 1, 0, 40'h600, '0, 0, 0, 128'h0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            t.exp_dc    = (k % 2 == 0);
            t.resp_data = rand128();
            run_txn(t, 1'b1);
        end
        clear_inputs();
        check("alt_ic_cnt", ic_grant_cnt_o, 2);
        check("alt_dc_cnt", dc_grant_cnt_o, 2);

        // A reset asserted while waiting for memory abandons the transaction.
        do_reset();
        bus.dc_req_valid_i = 1'b1;
        bus.dc_req_addr_i  = 40'h880;
        #1;
        check("midrst_ready", bus.dc_req_ready_o, 1);
        tick();
        bus.dc_req_valid_i  = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        tick();
        bus.mem_req_ready_i = 1'b0;
        check("midrst_in_wait", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check_outputs_zero("midrst");
        tick();
        rst_i = 1'b0;
        m_last_dc = 1'b0;
        m_ic_cnt  = 0;
        m_dc_cnt  = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("postrst_noresp", {bus.ic_resp_valid_o, bus.dc_resp_valid_o}, 0);
            check("postrst_busy", busy_o, 0);
            check("postrst_cnts", {ic_grant_cnt_o, dc_grant_cnt_o}, 0);
        end
        run_txn(mk(1, 40'h900, 0, 0, 40'h0, '0, 0, 0, 128'h4242, 0, 0, 0), 1'b0);

        // Counter wrap from 2^CNT_W-1 back to 0.
        do_reset();
        t = mk(1, 40'hA00, 0, 0, 40'h0, '0, 0, 0, 128'h1, 0, 0, 0);
        for (int k = 0; k < 15; k++) run_txn(t, 1'b0);
        check("wrap_pre", ic_grant_cnt_o, 15);
        run_txn(t, 1'b0);
        check("wrap_post", ic_grant_cnt_o, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = $urandom_range(1, 3);
            t.ic_v        = sel[0];
            t.dc_v        = sel[1];
            t.ic_addr     = rand_addr();
            t.dc_addr     = rand_addr();
            t.dc_we       = 1'($urandom);
            t.dc_wdata    = rand128();
            t.ready_delay = $urandom_range(0, 4);
            t.resp_delay  = $urandom_range(0, 3);
            t.resp_data   = rand128();
            t.spur_idle   = 1'($urandom);
            t.spur_req    = 1'($urandom);
            t.exp_dc      = (t.ic_v && t.dc_v) ? !m_last_dc : t.dc_v;
            run_txn(t, 1'b0);
        end

        check("never_both_ready", both_ready_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
